switch_merge: RTL and testbench

Two-to-one merge for the address/data stream: accepts words from port A and port B, buffers each port in a small FIFO, and emits them on a single output port. It is the return-direction counterpart of the address-splitting switch, recombining the A and B legs into one stream. Arbitration is round-robin, and the downstream consumer can apply backpressure.

---
 rtl/switch_pkg.sv | 33 +++
 rtl/switch_merge_fifo.sv | 85 ++++++++
 rtl/switch_merge.sv | 120 ++++++++++++
 tb/tb_switch_merge.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared types and default widths for the A/B merge datapath.
package switch_pkg;

  // Identifies which input leg a word came from; also used as the
  // arbiter's last-grant memory.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_e;

  // Default address/data widths shared by the split and merge blocks.
  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_DATA_WIDTH = 16;

  // Round-robin pick between two requesters: when both ask, the one that
  // was not served last wins; otherwise whoever asks wins.  With no
  // request the result is don't-care (PORT_B is returned).
  function automatic port_id_e rr_pick(input logic     req_a,
                                       input logic     req_b,
                                       input port_id_e last);
    port_id_e pick;
    pick = PORT_B;
    if (req_a && req_b) begin
      pick = (last == PORT_A) ? PORT_B : PORT_A;
    end else if (req_a) begin
      pick = PORT_A;
    end else begin
      pick = PORT_B;
    end
    return pick;
  endfunction

endpackage

// File: rtl/switch_merge_fifo.sv
// Per-port input FIFO storing {addr, data} words in arrival order.
// Handshake: a word is written when push is high and the FIFO is not
// full; the head is removed when pop is high and the FIFO is not empty.
// full/empty come straight from the registered count, so the upstream
// ready derived from them has no combinational path from any valid or
// ready.  A full FIFO refuses a write even in a cycle where it pops.
module switch_merge_fifo
  import switch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           push,
  input  logic                           pop,
  input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] din,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0] dout,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned W  = ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  // Status and qualified push/pop strobes.
  always_comb begin
    w_full    = (r_count == CW'(FIFO_DEPTH));
    w_empty   = (r_count == '0);
    w_do_push = push && !w_full;
    w_do_pop  = pop && !w_empty;
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Occupancy count; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else begin
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = w_full;
  assign empty = w_empty;

endmodule

// File: rtl/switch_merge.sv
// Two-to-one merge: buffers port A and port B in their own FIFOs and
// drains them round-robin into one registered output stage.
// Handshake (all three ports): a word moves on a rising edge where valid
// and ready are both high.  rdy_a/rdy_b are registered-state only; the
// output stage holds addr/data/src stable while vld is high and rdy low.
module switch_merge
  import switch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  vld_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic                  rdy_a,
  input  logic                  vld_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  rdy_b,
  output logic                  vld,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  src,
  input  logic                  rdy
);

  localparam int unsigned W = ADDR_WIDTH + DATA_WIDTH;

  logic [W-1:0] w_head_a;
  logic [W-1:0] w_head_b;
  logic         w_full_a;
  logic         w_full_b;
  logic         w_empty_a;
  logic         w_empty_b;
  logic         w_pop_a;
  logic         w_pop_b;
  logic         w_load;
  logic         w_any;
  port_id_e     w_grant;
  logic [W-1:0] w_head;

  logic                  r_vld;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  port_id_e              r_src;
  port_id_e              r_last;

  switch_merge_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_a (
    .clk   (clk),
    .rstn  (rstn),
    .push  (vld_a),
    .pop   (w_pop_a),
    .din   ({addr_a, data_a}),
    .dout  (w_head_a),
    .full  (w_full_a),
    .empty (w_empty_a)
  );

  switch_merge_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo_b (
    .clk   (clk),
    .rstn  (rstn),
    .push  (vld_b),
    .pop   (w_pop_b),
    .din   ({addr_b, data_b}),
    .dout  (w_head_b),
    .full  (w_full_b),
    .empty (w_empty_b)
  );

  // Arbitration: the output stage may load when empty or being drained;
  // the granted FIFO pops only on such a load.
  always_comb begin
    w_load  = !r_vld || rdy;
    w_any   = !w_empty_a || !w_empty_b;
    w_grant = rr_pick(!w_empty_a, !w_empty_b, r_last);
    w_pop_a = w_load && w_any && (w_grant == PORT_A);
    w_pop_b = w_load && w_any && (w_grant == PORT_B);
    w_head  = (w_grant == PORT_A) ? w_head_a : w_head_b;
  end

  // Output register stage and last-grant memory (updates only on a pop).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_src  <= PORT_A;
      r_last <= PORT_B;
    end else if (w_load) begin
      if (w_any) begin
        r_vld  <= 1'b1;
        r_addr <= w_head[W-1:DATA_WIDTH];
        r_data <= w_head[DATA_WIDTH-1:0];
        r_src  <= w_grant;
        r_last <= w_grant;
      end else begin
        r_vld  <= 1'b0;
      end
    end
  end

  assign rdy_a = !w_full_a;
  assign rdy_b = !w_full_b;
  assign vld   = r_vld;
  assign addr  = r_addr;
  assign data  = r_data;
  assign src   = r_src;

endmodule

// File: tb/tb_switch_merge.sv
// Directed bench for switch_merge: a cycle table for the basic paths,
// then hand-written backpressure, saturation, wrap and reset sequences.
module tb_switch_merge;
  import switch_pkg::*;

  localparam int AW    = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int W     = AW + DW;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic          vld_a = 1'b0;
  logic [AW-1:0] addr_a = '0;
  logic [DW-1:0] data_a = '0;
  logic          rdy_a;
  logic          vld_b = 1'b0;
  logic [AW-1:0] addr_b = '0;
  logic [DW-1:0] data_b = '0;
  logic          rdy_b;
  logic          vld;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          src;
  logic          rdy = 1'b0;

  switch_merge #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .vld_a  (vld_a),
    .addr_a (addr_a),
    .data_a (data_a),
    .rdy_a  (rdy_a),
    .vld_b  (vld_b),
    .addr_b (addr_b),
    .data_b (data_b),
    .rdy_b  (rdy_b),
    .vld    (vld),
    .addr   (addr),
    .data   (data),
    .src    (src),
    .rdy    (rdy)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  int   outstanding = 0;
  logic chk_alt     = 1'b0;
  logic prev_src    = 1'b1;

  typedef struct {
    logic          va;
    logic [AW-1:0] aa;
    logic [DW-1:0] da;
    logic          vb;
    logic [AW-1:0] ab;
    logic [DW-1:0] db;
    logic          r;
    logic          e_vld;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_src;
    logic          e_rdy_a;
    logic          e_rdy_b;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic va, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                              input logic vb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                              input logic r, input logic ev, input logic [AW-1:0] ea,
                              input logic [DW-1:0] ed, input logic es);
    vec_t v;
    v.va = va; v.aa = aa; v.da = da;
    v.vb = vb; v.ab = ab; v.db = db;
    v.r  = r;
    v.e_vld = ev; v.e_addr = ea; v.e_data = ed; v.e_src = es;
    v.e_rdy_a = 1'b1; v.e_rdy_b = 1'b1;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    vld_a = 1'b0; addr_a = '0; data_a = '0;
    vld_b = 1'b0; addr_b = '0; data_b = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn = 1'b0;
    idle_inputs();
    rdy = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    exp_a_q.delete();
    exp_b_q.delete();
    outstanding = 0;
    chk_alt  = 1'b0;
    prev_src = 1'b1;
  endtask

  // Output-side check of one transferred word against the per-port queue.
  task automatic sb_pop();
    logic [W-1:0] e;
    if (src == 1'b0) begin
      if (exp_a_q.size() == 0) begin
        check("unexpected_a_word", {addr, data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_a_q.pop_front();
        check("out_word_a", {addr, data}, e);
      end
    end else begin
      if (exp_b_q.size() == 0) begin
        check("unexpected_b_word", {addr, data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_b_q.pop_front();
        check("out_word_b", {addr, data}, e);
      end
    end
    if (chk_alt) begin
      check("alternate_src", src, !prev_src);
      prev_src = src;
    end
  endtask

  // Called at a negedge with inputs already set: record the handshakes
  // that the coming rising edge will complete, then advance one cycle.
  task automatic tick();
    if (vld_a && rdy_a) begin
      exp_a_q.push_back({addr_a, data_a});
      outstanding++;
    end
    if (vld_b && rdy_b) begin
      exp_b_q.push_back({addr_b, data_b});
      outstanding++;
    end
    if (vld && rdy) begin
      sb_pop();
      outstanding--;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    rdy = 1'b1;
    idle_inputs();
    while (outstanding > 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, outstanding, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int accepted;
    int sent;
    int cyc;

    vecs[0]  = mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 1, 0, 8'h00, 16'h0000, 0);
    vecs[1]  = mk(1, 8'h20, 16'h1111, 1, 8'h30, 16'h2222, 1, 0, 8'h00, 16'h0000, 0);
    vecs[2]  = mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 1, 1, 8'h20, 16'h1111, 0);
    vecs[3]  = mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 1, 1, 8'h30, 16'h2222, 1);
    vecs[4]  = mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 1, 0, 8'h30, 16'h2222, 1);
    vecs[5]  = mk(1, 8'h10, 16'hBEEF, 0, 8'h00, 16'h0000, 1, 0, 8'h30, 16'h2222, 1);
    vecs[6]  = mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 1, 1, 8'h10, 16'hBEEF, 0);
    vecs[7]  = mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 1, 0, 8'h10, 16'hBEEF, 0);
    vecs[8]  = mk(0, 8'h00, 16'h0000, 1, 8'h44, 16'h4444, 0, 0, 8'h10, 16'hBEEF, 0);
    vecs[9]  = mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 0, 1, 8'h44, 16'h4444, 1);
    vecs[10] = mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 0, 1, 8'h44, 16'h4444, 1);
    vecs[11] = mk(0, 8'h00, 16'h0000, 0, 8'h00, 16'h0000, 1, 0, 8'h44, 16'h4444, 1);

    // Reset state while rstn is still low.
    repeat (2) @(negedge clk);
    check("reset_vld", vld, 0);
    check("reset_addr", addr, 0);
    check("reset_data", data, 0);
    check("reset_src", src, 0);
    rstn = 1'b1;

    // Cycle table: simultaneous arrival, single A word, B word under hold.
    for (int i = 0; i < 12; i++) begin
      vld_a = vecs[i].va; addr_a = vecs[i].aa; data_a = vecs[i].da;
      vld_b = vecs[i].vb; addr_b = vecs[i].ab; data_b = vecs[i].db;
      rdy   = vecs[i].r;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_vld", i),   vld,   vecs[i].e_vld);
      check($sformatf("vec%0d_addr", i),  addr,  vecs[i].e_addr);
      check($sformatf("vec%0d_data", i),  data,  vecs[i].e_data);
      check($sformatf("vec%0d_src", i),   src,   vecs[i].e_src);
      check($sformatf("vec%0d_rdy_a", i), rdy_a, vecs[i].e_rdy_a);
      check($sformatf("vec%0d_rdy_b", i), rdy_b, vecs[i].e_rdy_b);
    end

    // Backpressure: 6 attempts on A with rdy low; 4 in FIFO + 1 in output.
    apply_reset();
    rdy = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      vld_a  = 1'b1;
      addr_a = AW'(8'h40 + i);
      data_a = DW'(16'hA000 + i);
      if (rdy_a) accepted++;
      tick();
    end
    vld_a = 1'b0;
    check("bp_accepted", accepted, 5);
    check("bp_rdy_a_low", rdy_a, 0);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_vld", vld, 1);
      check("bp_hold_addr", addr, 8'h40);
      check("bp_hold_data", data, 16'hA000);
      tick();
    end
    drain("bp_drain", 30);
    check("bp_rdy_a_back", rdy_a, 1);

    // Saturation: both ports valid every cycle, output alternates from A.
    apply_reset();
    rdy      = 1'b1;
    chk_alt  = 1'b1;
    prev_src = 1'b1;
    for (int i = 0; i < 20; i++) begin
      vld_a = 1'b1; addr_a = AW'(i);         data_a = DW'($urandom_range(0, 16'hFFFF));
      vld_b = 1'b1; addr_b = AW'(8'h80 + i); data_b = DW'($urandom_range(0, 16'hFFFF));
      tick();
    end
    chk_alt = 1'b0;
    drain("sat_drain", 40);

    // Wrap on B: 3*DEPTH words under a random rdy pattern.
    apply_reset();
    sent = 0;
    cyc  = 0;
    while (sent < 3 * DEPTH && cyc < 300) begin
      vld_b  = 1'b1;
      addr_b = AW'(8'hC0 + sent);
      data_b = DW'(16'hB000 + sent);
      rdy    = 1'($urandom_range(0, 1));
      if (rdy_b) sent++;
      tick();
      check("wrap_occupancy", (outstanding <= DEPTH + 1), 1);
      cyc++;
    end
    check("wrap_sent", sent, 3 * DEPTH);
    drain("wrap_drain", 40);

    // Asynchronous reset in the middle of held traffic.
    apply_reset();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vld_a = 1'b1; addr_a = 8'h5A; data_a = 16'hC3C3;
      vld_b = 1'b1; addr_b = 8'h6B; data_b = 16'hD4D4;
      tick();
    end
    check("pre_reset_vld", vld, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("async_reset_vld", vld, 0);
    check("async_reset_addr", addr, 0);
    check("async_reset_data", data, 0);
    check("async_reset_src", src, 0);
    idle_inputs();
    exp_a_q.delete();
    exp_b_q.delete();
    outstanding = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("post_reset_rdy_a", rdy_a, 1);
    check("post_reset_rdy_b", rdy_b, 1);
    check("post_reset_vld", vld, 0);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
